// File: rtl/alu_operand_sequencer.sv
// Operand-entry and result-capture stage for the 3-bit ALU: one field per enter press,
// then a settle interval before alu_q is registered for display.
module alu_operand_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [2:0] sw_data,
    input  logic [1:0] sw_sel,
    input  logic [3:0] alu_q,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_sel,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic [1:0] phase
);
    typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, SETTLE, SHOW} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     r_state, w_next;
    logic       r_en_s1, r_en_s2, r_en_prev;
    logic       r_cl_s1, r_cl_s2;
    logic [2:0] r_a, r_b;
    logic [1:0] r_sel;
    logic [3:0] r_res, r_cnt;
    logic       r_valid;
    logic       w_enter, w_clear;
    logic [1:0] w_phase;

    assign w_enter = r_en_s2 & ~r_en_prev;
    assign w_clear = r_cl_s2;

    // Both buttons are asynchronous; the extra enter flop turns a held press into one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_s1   <= 1'b0;
            r_en_s2   <= 1'b0;
            r_en_prev <= 1'b0;
            r_cl_s1   <= 1'b0;
            r_cl_s2   <= 1'b0;
        end else begin
            r_en_s1   <= btn_enter;
            r_en_s2   <= r_en_s1;
            r_en_prev <= r_en_s2;
            r_cl_s1   <= btn_clear;
            r_cl_s2   <= r_cl_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD_A;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_clear) begin
            w_next = LOAD_A;
        end else begin
            case (r_state)
                LOAD_A:  if (w_enter) w_next = LOAD_B;
                LOAD_B:  if (w_enter) w_next = LOAD_OP;
                LOAD_OP: if (w_enter) w_next = SETTLE;
                SETTLE:  if (r_cnt == 4'd0) w_next = SHOW;
                SHOW:    if (w_enter) w_next = LOAD_A;
                default: w_next = LOAD_A;
            endcase
        end
    end

    always_comb begin
        w_phase = 2'b00;
        case (r_state)
            LOAD_A:       w_phase = 2'b00;
            LOAD_B:       w_phase = 2'b01;
            LOAD_OP:      w_phase = 2'b10;
            SETTLE, SHOW: w_phase = 2'b11;
            default:      w_phase = 2'b00;
        endcase
    end

    // Clear wipes the datapath along with the state so stale operands never reach the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 3'd0;
            r_b     <= 3'd0;
            r_sel   <= 2'd0;
            r_res   <= 4'd0;
            r_cnt   <= 4'd0;
            r_valid <= 1'b0;
        end else if (w_clear) begin
            r_a     <= 3'd0;
            r_b     <= 3'd0;
            r_sel   <= 2'd0;
            r_res   <= 4'd0;
            r_cnt   <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A:  if (w_enter) r_a <= sw_data;
                LOAD_B:  if (w_enter) r_b <= sw_data;
                LOAD_OP: if (w_enter) begin
                    r_sel <= sw_sel;
                    r_cnt <= CNT_INIT;
                end
                SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_res   <= alu_q;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                SHOW:    if (w_enter) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_sel      = r_sel;
    assign result       = r_res;
    assign result_valid = r_valid;
    assign busy         = (r_state == SETTLE);
    assign phase        = w_phase;
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream operand-entry and result-capture stage for the combinational 3-bit ALU.
- Collects operand a, operand b and the 2-bit op select from shared switches, one field per button press.
- Holds the three fields stable on the ALU inputs, waits a settle interval, then registers the ALU's 4-bit result for display.
- Sits between board switches/buttons and the ALU; the ALU's q returns to this block.

Parameters:
SETTLE_CYCLES, 2, clock cycles between operand/select commit and result capture; legal range 1..15.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_enter  input  1  raw enter push-button, asynchronous to clk
btn_clear  input  1  raw clear push-button, asynchronous to clk
sw_data  input  3  operand switches
sw_sel  input  2  op-select switches
alu_q  input  4  result from ALU
alu_a  output  3  operand a to ALU
alu_b  output  3  operand b to ALU
alu_sel  output  2  op select to ALU
result  output  4  registered ALU result
result_valid  output  1  high while result belongs to the current operand set
busy  output  1  high during SETTLE
phase  output  2  entry-phase indicator for LEDs

Behaviour:
- Reset (rst_n=0, asynchronous):
  - alu_a, alu_b, alu_sel, result, result_valid, busy and phase all 0.
  - State LOAD_A; all synchroniser and edge flops 0.
- Input conditioning:
  - btn_enter and btn_clear each pass through a 2-flop synchroniser.
  - enter_pulse = sync2 & ~prev. A raw rise sampled at edge 1 is acted on at edge 3.
  - A button held high yields exactly one pulse.
  - clear is level-sensitive after synchronisation.
- alu_a, alu_b and alu_sel are driven directly from internal registers. They never follow the switches combinationally.
- FSM states and transitions:
  - LOAD_A (phase=00): enter_pulse captures sw_data into a_reg, then go to LOAD_B.
  - LOAD_B (phase=01): enter_pulse captures sw_data into b_reg, then go to LOAD_OP.
  - LOAD_OP (phase=10): enter_pulse captures sw_sel into sel_reg, loads cnt=SETTLE_CYCLES-1, then go to SETTLE.
  - SETTLE (phase=11, busy=1): decrement cnt each cycle. When cnt==0, capture alu_q into result, set result_valid=1, go to SHOW. Result is captured on the SETTLE_CYCLES-th edge after entering SETTLE. enter_pulse is ignored and discarded.
  - SHOW (phase=11, busy=0): result held. enter_pulse clears result_valid and goes to LOAD_A. a_reg, b_reg, sel_reg and result keep their values until overwritten.
- Clear (synchronised btn_clear=1), any state:
  - Next edge: state LOAD_A; a_reg, b_reg, sel_reg, result and cnt set to 0; result_valid=0, busy=0.
  - Clear has priority over a simultaneous enter_pulse.
- Reset asserted mid-operation, including SETTLE: immediate return to reset values. No partial capture survives.
- result is a straight copy of alu_q with no arithmetic applied. Width is 4 bits; the ALU supplies the carry or borrow in bit 3.
- Switch changes in any state are ignored except at the capture edge of the corresponding phase.
- cnt width: 4 bits, sufficient for the legal SETTLE_CYCLES range.

Test Plan:
- Reset, then a=3, b=5, sel=00, ALU model a+b -> result=4'b1000 and result_valid=1 exactly SETTLE_CYCLES edges after entering SETTLE; busy high for exactly SETTLE_CYCLES cycles.
- a=5, b=3, sel=01, ALU model a-b -> result=4'b0010; phase sequence 00,01,10,11 observed.
- btn_enter held high for 20 cycles in LOAD_A -> only a_reg loads; state = LOAD_B, not LOAD_OP.
- Enter pressed during SETTLE -> ignored; after capture, state SHOW persists until a fresh press, which returns to LOAD_A and drops result_valid.
- btn_clear and btn_enter raised together in LOAD_B -> state LOAD_A; alu_a, alu_b, alu_sel and result all 0.
- rst_n pulsed low mid-SETTLE -> all outputs 0 immediately while rst_n is low; after release a full a/b/op entry yields a correct result.
